// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR sequencing controller.
// Holds the state/opcode enums and the per-state output decode helpers.
package fir_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_STORE      = 3'd1,
      ST_CLR_ACC    = 3'd2,
      ST_MAC        = 3'd3,
      ST_DONE       = 3'd4,
      ST_LOAD_COEFF = 3'd5,
      ST_ERR        = 3'd6
   } fir_state_t;

   typedef enum logic [2:0] {
      OP_NOP         = 3'd0,
      OP_LOAD_SAMPLE = 3'd1,
      OP_CLEAR_ACC   = 3'd2,
      OP_MAC         = 3'd3,
      OP_LOAD_COEFF  = 3'd4
   } fir_op_t;

   localparam int FIR_NUM_TAPS     = 4;
   localparam int FIR_SAMPLE_LIMIT = 1000;

   function automatic fir_op_t state_op(input fir_state_t s);
      fir_op_t o;
      case (s)
         ST_STORE:      o = OP_LOAD_SAMPLE;
         ST_CLR_ACC:    o = OP_CLEAR_ACC;
         ST_MAC:        o = OP_MAC;
         ST_LOAD_COEFF: o = OP_LOAD_COEFF;
         default:       o = OP_NOP;
      endcase
      return o;
   endfunction

   function automatic logic state_busy(input fir_state_t s);
      logic b;
      case (s)
         ST_STORE, ST_CLR_ACC, ST_MAC, ST_DONE, ST_LOAD_COEFF: b = 1'b1;
         default:                                              b = 1'b0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/fir_sample_counter.sv
// Completed-sample counter: clear beats enable, and the count wraps from
// LIMIT to 1 so a zero count only ever means "cleared or reset".
module fir_sample_counter
   import fir_pkg::*;
#(
   parameter int CNT_BITS = 10,
   parameter int LIMIT    = FIR_SAMPLE_LIMIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic at_limit
);

   logic [CNT_BITS-1:0] count_r;
   logic [CNT_BITS-1:0] nxt_count_s;

   // Next count with wrap-to-1 rollover.
   always_comb begin
      nxt_count_s = count_r;
      if (count_r == CNT_BITS'(LIMIT)) begin
         nxt_count_s = CNT_BITS'(1);
      end else begin
         nxt_count_s = count_r + CNT_BITS'(1);
      end
   end

   // Count and limit flag registers.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_r  <= CNT_BITS'(0);
         at_limit <= 1'b0;
      end else if (en) begin
         count_r  <= nxt_count_s;
         at_limit <= (nxt_count_s == CNT_BITS'(LIMIT));
      end else begin
         count_r  <= count_r;
         at_limit <= at_limit;
      end
   end

endmodule

// File: rtl/fir_controller.sv
// FIR datapath sequencer: sample store, accumulator clear, per-tap MAC loop
// and coefficient loading, with a 1-deep request buffer and sample counting.
module fir_controller
   import fir_pkg::*;
#(
   parameter int NUM_TAPS     = FIR_NUM_TAPS,
   parameter int SAMPLE_LIMIT = FIR_SAMPLE_LIMIT,
   parameter int CNT_BITS     = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        data_ready,
   input  logic                        coeff_load,
   input  logic                        overflow,
   input  logic                        clear,
   output fir_op_t                     op,
   output logic [$clog2(NUM_TAPS)-1:0] tap_sel,
   output logic                        modwait,
   output logic                        cnt_up,
   output logic                        one_k_samples,
   output logic                        err
);

   localparam int TAP_W = $clog2(NUM_TAPS);
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

   fir_state_t       state_r;
   fir_state_t       nxt_state_s;
   logic [TAP_W-1:0] nxt_tap_s;
   logic             pending_r;
   logic             nxt_pending_s;
   logic             req_s;
   logic             busy_s;
   logic             overrun_s;

   assign req_s     = pending_r | data_ready;
   assign busy_s    = state_busy(state_r);
   // A second request while one is already buffered is dropped and flagged.
   assign overrun_s = data_ready & pending_r & busy_s;
   assign nxt_pending_s = (nxt_state_s == ST_STORE) ? 1'b0 : (pending_r | data_ready);

   // Next-state and tap index logic.
   always_comb begin
      nxt_state_s = state_r;
      nxt_tap_s   = TAP_W'(0);
      case (state_r)
         ST_IDLE, ST_ERR: begin
            if (coeff_load) begin
               nxt_state_s = ST_LOAD_COEFF;
            end else if (req_s) begin
               nxt_state_s = ST_STORE;
            end else begin
               nxt_state_s = state_r;
            end
         end
         ST_STORE:   nxt_state_s = ST_CLR_ACC;
         ST_CLR_ACC: nxt_state_s = ST_MAC;
         ST_MAC: begin
            if (overflow) begin
               nxt_state_s = ST_ERR;
            end else if (tap_sel == LAST_TAP) begin
               nxt_state_s = ST_DONE;
            end else begin
               nxt_state_s = ST_MAC;
               nxt_tap_s   = tap_sel + TAP_W'(1);
            end
         end
         ST_DONE: begin
            if (req_s) begin
               nxt_state_s = ST_STORE;
            end else begin
               nxt_state_s = ST_IDLE;
            end
         end
         ST_LOAD_COEFF: begin
            if (tap_sel != LAST_TAP) begin
               nxt_state_s = ST_LOAD_COEFF;
               nxt_tap_s   = tap_sel + TAP_W'(1);
            end else if (req_s) begin
               nxt_state_s = ST_STORE;
            end else begin
               nxt_state_s = ST_IDLE;
            end
         end
         default: nxt_state_s = ST_IDLE;
      endcase
   end

   // State, pending flag and registered Moore outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         pending_r <= 1'b0;
         tap_sel   <= TAP_W'(0);
         op        <= OP_NOP;
         modwait   <= 1'b0;
         cnt_up    <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_r   <= nxt_state_s;
         pending_r <= nxt_pending_s;
         tap_sel   <= nxt_tap_s;
         op        <= state_op(nxt_state_s);
         modwait   <= state_busy(nxt_state_s);
         cnt_up    <= (nxt_state_s == ST_DONE);
         err       <= (nxt_state_s == ST_ERR) | overrun_s;
      end
   end

   fir_sample_counter #(
      .CNT_BITS (CNT_BITS),
      .LIMIT    (SAMPLE_LIMIT)
   ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .en       (cnt_up),
      .at_limit (one_k_samples)
   );

endmodule

// File: tb/tb_fir_controller.sv
// Directed bench for fir_controller: per-cycle vector table for the opcode
// sequences, plus hand-written reset, counter-boundary and clear sequences.
module tb_fir_controller;
   import fir_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       data_ready = 1'b0;
   logic       coeff_load = 1'b0;
   logic       overflow = 1'b0;
   logic       clear = 1'b0;
   fir_op_t    op;
   logic [1:0] tap_sel;
   logic       modwait;
   logic       cnt_up;
   logic       one_k_samples;
   logic       err;

   int tot = 0;
   int bad = 0;

   typedef struct {
      logic       dr, cl, ov, cr;
      logic [2:0] op;
      logic [1:0] tap;
      logic       mw, cu, er;
   } vec_t;

   vec_t vecs[$];

   fir_controller dut (
      .clk           (clk),
      .rst           (rst),
      .data_ready    (data_ready),
      .coeff_load    (coeff_load),
      .overflow      (overflow),
      .clear         (clear),
      .op            (op),
      .tap_sel       (tap_sel),
      .modwait       (modwait),
      .cnt_up        (cnt_up),
      .one_k_samples (one_k_samples),
      .err           (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tot++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t v(input int dr, cl, ov, cr, o, t, mw, cu, er);
      vec_t r;
      r.dr = 1'(dr); r.cl = 1'(cl); r.ov = 1'(ov); r.cr = 1'(cr);
      r.op = 3'(o);  r.tap = 2'(t);
      r.mw = 1'(mw); r.cu = 1'(cu); r.er = 1'(er);
      return r;
   endfunction

   // CLR_ACC, MAC x4, DONE, IDLE following a STORE row.
   task automatic push_tail();
      vecs.push_back(v(0,0,0,0, 2,0,1,0,0));
      for (int t = 0; t < 4; t++) vecs.push_back(v(0,0,0,0, 3,t,1,0,0));
      vecs.push_back(v(0,0,0,0, 0,0,1,1,0));
      vecs.push_back(v(0,0,0,0, 0,0,0,0,0));
   endtask

   task automatic run_sample(input bit clr_at_done);
      bit seen;
      seen = 1'b0;
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (cnt_up) seen = 1'b1;
      end
      clear = clr_at_done;
      tick();
      clear = 1'b0;
      tot++;
      if (!seen) begin
         bad++;
         $display("FAIL sample_timeout: cnt_up not seen within 20 cycles");
      end
   endtask

   initial begin
      // Single sample.
      vecs.push_back(v(1,0,0,0, 1,0,1,0,0));
      push_tail();
      // coeff_load and data_ready together: coefficients first, then the sample.
      vecs.push_back(v(1,1,0,0, 4,0,1,0,0));
      for (int t = 1; t < 4; t++) vecs.push_back(v(0,0,0,0, 4,t,1,0,0));
      vecs.push_back(v(0,0,0,0, 1,0,1,0,0));
      push_tail();
      // Overflow during MAC tap 2, linger in ERR, restart.
      vecs.push_back(v(1,0,0,0, 1,0,1,0,0));
      vecs.push_back(v(0,0,0,0, 2,0,1,0,0));
      for (int t = 0; t < 3; t++) vecs.push_back(v(0,0,0,0, 3,t,1,0,0));
      vecs.push_back(v(0,0,1,0, 0,0,0,0,1));
      vecs.push_back(v(0,0,0,0, 0,0,0,0,1));
      vecs.push_back(v(1,0,0,0, 1,0,1,0,0));
      push_tail();
      // Three requests two cycles apart.
      vecs.push_back(v(1,0,0,0, 1,0,1,0,0));
      vecs.push_back(v(0,0,0,0, 2,0,1,0,0));
      vecs.push_back(v(1,0,0,0, 3,0,1,0,0));
      vecs.push_back(v(0,0,0,0, 3,1,1,0,0));
      vecs.push_back(v(1,0,0,0, 3,2,1,0,1));
      vecs.push_back(v(0,0,0,0, 3,3,1,0,0));
      vecs.push_back(v(0,0,0,0, 0,0,1,1,0));
      vecs.push_back(v(0,0,0,0, 1,0,1,0,0));
      push_tail();

      // Reset state.
      tick();
      tick();
      check("reset_outputs", 32'({op, tap_sel, modwait, cnt_up, err}), 32'd0);
      check("reset_one_k", 32'(one_k_samples), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         data_ready = vecs[i].dr;
         coeff_load = vecs[i].cl;
         overflow   = vecs[i].ov;
         clear      = vecs[i].cr;
         tick();
         tot++;
         if ({op, tap_sel, modwait, cnt_up, err} !==
             {vecs[i].op, vecs[i].tap, vecs[i].mw, vecs[i].cu, vecs[i].er}) begin
            bad++;
            $display("FAIL vec[%0d]: got op=%0d tap=%0d mw=%0b cu=%0b err=%0b, expected op=%0d tap=%0d mw=%0b cu=%0b err=%0b",
                     i, op, tap_sel, modwait, cnt_up, err,
                     vecs[i].op, vecs[i].tap, vecs[i].mw, vecs[i].cu, vecs[i].er);
         end
      end
      data_ready = 1'b0; coeff_load = 1'b0; overflow = 1'b0; clear = 1'b0;

      // Reset in the middle of MAC with a request pending.
      data_ready = 1'b1; tick();
      data_ready = 1'b0; tick();
      data_ready = 1'b1; tick();
      data_ready = 1'b0; tick();
      check("mid_mac_op", 32'(op), 32'(OP_MAC));
      rst = 1'b1; tick();
      check("rst_mid_mac_outputs", 32'({op, tap_sel, modwait, cnt_up, err}), 32'd0);
      rst = 1'b0;
      begin
         bit activity;
         activity = 1'b0;
         for (int k = 0; k < 12; k++) begin
            tick();
            if (modwait || cnt_up) activity = 1'b1;
         end
         check("rst_drops_pending", 32'(activity), 32'd0);
      end
      check("rst_count_zero", 32'(dut.u_counter.count_r), 32'd0);

      // Counter boundaries.
      for (int s = 0; s < 999; s++) run_sample(1'b0);
      check("count_999", 32'(dut.u_counter.count_r), 32'd999);
      check("one_k_at_999", 32'(one_k_samples), 32'd0);
      run_sample(1'b0);
      check("count_1000", 32'(dut.u_counter.count_r), 32'd1000);
      check("one_k_at_1000", 32'(one_k_samples), 32'd1);
      run_sample(1'b0);
      check("count_wrap_1", 32'(dut.u_counter.count_r), 32'd1);
      check("one_k_after_wrap", 32'(one_k_samples), 32'd0);
      run_sample(1'b1);
      check("clear_beats_cnt_up", 32'(dut.u_counter.count_r), 32'd0);
      check("one_k_after_clear", 32'(one_k_samples), 32'd0);

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule

// File: doc/fir_controller.md
# fir_controller

Sequencing controller for the FIR filter datapath. Accepts sample-ready requests from the upstream interface and steps the datapath through sample store, accumulator clear and a per-tap multiply-accumulate loop. It also sequences coefficient loading and counts completed samples, raising a flag at the configured sample limit. It sits between the interface/handshake logic and the FIR datapath (delay line, coefficient registers, MAC accumulator).

## Interface
- NUM_TAPS, 4: FIR taps; MAC loop and coefficient-load loop length.
- SAMPLE_LIMIT, 1000: completed-sample count at which `one_k_samples` asserts.
- CNT_BITS, 10: sample counter width; must hold SAMPLE_LIMIT.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- data_ready  in  1  one-cycle pulse: new sample available.
- coeff_load  in  1  one-cycle pulse: load NUM_TAPS coefficients.
- overflow  in  1  datapath accumulator overflow, valid during MAC cycles.
- clear  in  1  synchronous clear of the sample counter.
- op  out  3  datapath opcode (package enum).
- tap_sel  out  $clog2(NUM_TAPS)  tap/coefficient index for the current op.
- modwait  out  1  controller busy.
- cnt_up  out  1  one-cycle pulse per completed sample.
- one_k_samples  out  1  sample count equals SAMPLE_LIMIT.
- err  out  1  overflow or request overrun.

## Operation
- States: IDLE, STORE, CLR_ACC, MAC, DONE, LOAD_COEFF, ERR.
- Moore outputs, decoded from the registered state.
- Opcodes by state:
  - IDLE: OP_NOP.
  - STORE: OP_LOAD_SAMPLE (shift the delay line).
  - CLR_ACC: OP_CLEAR_ACC.
  - MAC: OP_MAC.
  - LOAD_COEFF: OP_LOAD_COEFF.
  - DONE, ERR: OP_NOP.
- modwait = 1 in STORE, CLR_ACC, MAC, DONE and LOAD_COEFF; 0 in IDLE and ERR.
- IDLE transitions:
  - coeff_load → LOAD_COEFF. coeff_load takes priority when both requests arrive in the same cycle; the data_ready is latched as pending.
  - else data_ready or pending → STORE. Pending clears on entry to STORE.
- STORE → CLR_ACC → MAC.
- MAC: tap_sel steps 0..NUM_TAPS-1, one per cycle, then → DONE.
- LOAD_COEFF: tap_sel steps 0..NUM_TAPS-1, then → IDLE.
- tap_sel is 0 outside MAC and LOAD_COEFF.
- overflow sampled high in any MAC cycle → ERR next cycle. That sample is abandoned: no DONE, no cnt_up.
- DONE: cnt_up = 1, then → IDLE.
- ERR: err = 1. Exits to STORE on data_ready or pending; coeff_load exits to LOAD_COEFF. err clears on exit.
- Pending (1-deep):
  - A data_ready pulse while modwait = 1 sets pending.
  - A further data_ready pulse while pending is already set → err pulses for 1 cycle. The state is not disturbed and the extra request is dropped.
- Sample counter behaviour:
  - Increments on cnt_up.
  - At SAMPLE_LIMIT, the next increment wraps to 1, not 0.
  - one_k_samples = (count == SAMPLE_LIMIT).
  - clear zeroes the count and has priority over a same-cycle cnt_up.

## Timing
- rst: state IDLE, pending 0, count 0. All outputs 0; op = OP_NOP, tap_sel = 0.
- rst mid-operation aborts the sequence immediately, with no cnt_up.
- Sample path, data_ready in IDLE at cycle 0:
  - STORE at cycle 1, CLR_ACC at cycle 2.
  - MAC at cycles 3..2+NUM_TAPS.
  - DONE (cnt_up) at cycle 3+NUM_TAPS.
  - IDLE at cycle 4+NUM_TAPS.
  - modwait is high for NUM_TAPS+3 cycles (7 at the default).
- With pending set, DONE goes directly to STORE; modwait does not drop.
- Coefficient path: LOAD_COEFF for NUM_TAPS cycles, starting the cycle after the coeff_load request.
- one_k_samples rises in the cycle after the cnt_up that reaches SAMPLE_LIMIT.

## Structure
- Package `fir_pkg` holds:
  - state enum `fir_state_t`;
  - opcode enum `fir_op_t` (OP_NOP=0, OP_LOAD_SAMPLE=1, OP_CLEAR_ACC=2, OP_MAC=3, OP_LOAD_COEFF=4);
  - the default NUM_TAPS and SAMPLE_LIMIT constants.
- Sub-module `fir_sample_counter`: synchronous-reset counter with clear, enable and wrap-to-1 rollover flag, parameterised on CNT_BITS.
- The FSM, tap index and pending logic live in the top module.

## Test plan
- Reset, then a single data_ready → the opcode sequence is:
  - LOAD_SAMPLE, CLEAR_ACC;
  - MAC ×4 with tap_sel 0,1,2,3;
  - NOP with cnt_up = 1.
  - modwait is high for exactly 7 cycles.
- coeff_load and data_ready in the same cycle → LOAD_COEFF ×4 (tap_sel 0..3), then the sample sequence with no idle gap.
- overflow during the MAC cycle with tap_sel = 2 → ERR next cycle (err = 1, modwait = 0), no cnt_up; the next data_ready restarts at STORE.
- Three data_ready pulses 2 cycles apart → two samples are processed back-to-back, the third pulse gives a 1-cycle err, and cnt_up fires twice.
- Counter boundaries:
  - 1000 completed samples → one_k_samples high after the 1000th cnt_up.
  - The 1001st sample → count = 1 and the flag drops.
  - clear asserted together with cnt_up → count = 0.
- rst asserted in the middle of MAC → outputs are zero next cycle, with no cnt_up and pending cleared.
